// File: rtl/fpu_int_to_float_if.sv
// Handshake bundle between the integer source, the int-to-float converter and its consumer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
//
// Ports (signals):
//   in_valid, in_ready, in_data[INT_W]        integer operand handshake
//   out_valid, out_ready, out_data[32], out_inexact  converted operand handshake
// Modports: slave = converter view, master = surrounding producer/consumer view.
interface fpu_int_to_float_if #(
  parameter int INT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_inexact;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_inexact
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_inexact
  );
endinterface

// File: rtl/fpu_int_to_float.sv
// Signed integer -> FPU operand {sign, exp[5:0] bias BIAS, man[24:0], hidden 1}; zero -> 32'h0.
// Latency: out_valid after edge k+lz+2 (lz = leading zeros of |x|), after edge k for zero.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one bubble after DONE).
//
// Ports: clock, reset (async, active-low), io (fpu_int_to_float_if.slave):
//   in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_inexact.
// Build option: define FP_CONV_ROUND_EN for round-to-nearest-even, otherwise the
//   mantissa is truncated. out_inexact and latency do not depend on the option.
module fpu_int_to_float #(
  parameter int INT_W = 32,
  parameter int BIAS  = 31
) (
  input logic              clock,
  input logic              reset,
  fpu_int_to_float_if.slave io
);

  if (INT_W < 2 || INT_W > 32) begin : g_bad_int_w
    $error("fpu_int_to_float: INT_W must be in 2..32");
  end
  if (BIAS + INT_W - 1 > 63) begin : g_bad_bias
    $error("fpu_int_to_float: BIAS+INT_W-1 must not exceed 63");
  end

  // Fraction window below the hidden bit: at least 25 mantissa + guard + 1 sticky bit.
  localparam int         PW       = (INT_W - 1 > 27) ? INT_W - 1 : 27;
  localparam logic [6:0] EXP_INIT = 7'(BIAS + INT_W - 1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t           state;
  logic             sign_q;
  logic [INT_W-1:0] mag_q;
  logic [6:0]       exp_q;
  logic [31:0]      out_data_q;
  logic             out_inexact_q;

  // Magnitude of the incoming operand; -2^(INT_W-1) maps onto itself as unsigned.
  logic [INT_W-1:0] mag_in;
  assign mag_in = io.in_data[INT_W-1] ? ((~io.in_data) + {{(INT_W-1){1'b0}}, 1'b1})
                                      : io.in_data;

  // Rounding datapath, valid while in ROUND (mag_q normalised, MSB = hidden 1).
  logic [PW-1:0] frac;
  logic [24:0]   man;
  logic          guard;
  logic          sticky;
  logic          rnd_inc;
  logic [25:0]   man_rnd;
  logic [6:0]    exp_fin;

  always_comb begin
    frac              = '0;
    frac[PW-1 -: INT_W-1] = mag_q[INT_W-2:0];
    man               = frac[PW-1 -: 25];
    guard             = frac[PW-26];
    sticky            = |frac[PW-27:0];
`ifdef FP_CONV_ROUND_EN
    rnd_inc           = guard & (sticky | man[0]);
`else
    rnd_inc           = 1'b0;
`endif
    // A carry out of the mantissa leaves man_rnd[24:0] at zero and bumps the exponent.
    man_rnd           = {1'b0, man} + {25'd0, rnd_inc};
    exp_fin           = exp_q + {6'd0, man_rnd[25]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      sign_q        <= 1'b0;
      mag_q         <= '0;
      exp_q         <= '0;
      out_data_q    <= '0;
      out_inexact_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            sign_q <= io.in_data[INT_W-1];
            mag_q  <= mag_in;
            exp_q  <= EXP_INIT;
            if (mag_in == '0) begin
              out_data_q    <= '0;
              out_inexact_q <= 1'b0;
              state         <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end
        NORM: begin
          if (mag_q[INT_W-1]) begin
            state <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 7'd1;
          end
        end
        ROUND: begin
          // The 7-bit exponent is truncated to the 6-bit field by dropping its MSB.
          out_data_q    <= {sign_q, 31'({exp_fin, man_rnd[24:0]})};
          out_inexact_q <= guard | sticky;
          state         <= DONE;
        end
        DONE: begin
          if (io.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready    = (state == IDLE);
  assign io.out_valid   = (state == DONE);
  assign io.out_data    = out_data_q;
  assign io.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_fpu_int_to_float.sv
// Directed bench for fpu_int_to_float (INT_W=32, BIAS=31): vector table plus
// back-pressure and mid-conversion reset sequences.
module tb_fpu_int_to_float;

  logic clock;
  logic reset;

  fpu_int_to_float_if #(.INT_W(32)) bus ();

  fpu_int_to_float #(.INT_W(32), .BIAS(31)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inexact;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive an operand and return right after its accept edge (+1).
  task automatic start(input logic [31:0] d, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!bus.in_ready) ok = 1'b0;
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  vec_t tv [13];
  logic [31:0] held;
  int          lat;
  int          bad_cycles;
  bit          ok;

  initial begin
    tv[0]  = '{32'h0000_0001, 32'h3E00_0000, 1'b0, 33};
    tv[1]  = '{32'hFFFF_FFFF, 32'hBE00_0000, 1'b0, 33};
    tv[2]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 0};
    tv[3]  = '{32'h0000_0003, 32'h4100_0000, 1'b0, 32};
    tv[4]  = '{32'h0000_0002, 32'h4000_0000, 1'b0, 32};
    tv[5]  = '{32'h8000_0000, 32'hFC00_0000, 1'b0, 2};
    tv[6]  = '{32'h0200_0001, 32'h7000_0001, 1'b0, 8};
    tv[7]  = '{32'h0400_0001, 32'h7200_0000, 1'b1, 7};   // tie, even -> unchanged
    tv[8]  = '{32'hFBFF_FFFB, 32'hF200_0002, 1'b1, 7};   // -0x04000005, tie even
    tv[9]  = '{32'h0800_0001, 32'h7400_0000, 1'b1, 6};   // sticky only
`ifdef FP_CONV_ROUND_EN
    tv[10] = '{32'h7FFF_FFFF, 32'h7C00_0000, 1'b1, 3};   // mantissa carry
    tv[11] = '{32'h0400_0003, 32'h7200_0002, 1'b1, 7};   // tie, odd -> up
    tv[12] = '{32'h0400_0007, 32'h7200_0004, 1'b1, 7};
`else
    tv[10] = '{32'h7FFF_FFFF, 32'h7BFF_FFFF, 1'b1, 3};
    tv[11] = '{32'h0400_0003, 32'h7200_0001, 1'b1, 7};
    tv[12] = '{32'h0400_0007, 32'h7200_0003, 1'b1, 7};
`endif

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset in_ready",    32'(bus.in_ready),    32'd1);
    check("reset out_valid",   32'(bus.out_valid),   32'd0);
    check("reset out_data",    bus.out_data,         32'h0);
    check("reset out_inexact", 32'(bus.out_inexact), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      start(tv[i].din, ok);
      check($sformatf("v%0d accept", i), 32'(ok), 32'd1);
      wait_out(lat);
      check($sformatf("v%0d data %h", i, tv[i].din), bus.out_data, tv[i].dout);
      check($sformatf("v%0d inexact", i), 32'(bus.out_inexact), 32'(tv[i].inexact));
      check($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].lat));
      @(posedge clock);
      #1;
    end

    // Back-pressure: 5 -> 0x42800000 held while out_ready is low.
    bus.out_ready = 1'b0;
    start(32'd5, ok);
    wait_out(lat);
    check("bp data", bus.out_data, 32'h4280_0000);
    check("bp latency", 32'(lat), 32'd31);
    held = bus.out_data;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd1;
    bad_cycles   = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.out_data !== held || !bus.out_valid || bus.in_ready) bad_cycles++;
    end
    check("bp stable cycles bad", 32'(bad_cycles), 32'd0);
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    check("bp bubble out_valid", 32'(bus.out_valid), 32'd0);
    check("bp bubble in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clock);
    #1 bus.in_valid = 1'b0;
    check("bp second accepted", 32'(bus.in_ready), 32'd0);
    wait_out(lat);
    check("bp second data", bus.out_data, 32'h3E00_0000);
    check("bp second latency", 32'(lat), 32'd33);
    @(posedge clock);
    #1;

    // Reset during NORM aborts the conversion.
    start(32'd1, ok);
    repeat (5) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst out_data",  bus.out_data,       32'h0);
    @(negedge clock);
    reset = 1'b1;
    start(32'd3, ok);
    check("post-rst accept", 32'(ok), 32'd1);
    wait_out(lat);
    check("post-rst latency", 32'(lat), 32'd32);
    check("post-rst data", bus.out_data, 32'h4100_0000);
    @(posedge clock);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
